// File: rtl/switch_conditioner.sv
// switch_conditioner: board switch/button front end for the A/B/C gate inputs.
// Each channel passes through a two-flop synchroniser and a counter debounce;
// a new level must persist DEBOUNCE_CYCLES synchronised cycles before it is
// accepted onto clean_out.
// Optional macro SWITCH_COND_EDGE_EN: when defined, registered one-cycle
// rise/fall pulses and a combined change strobe are generated; when undefined
// those outputs are tied to 0 and clean_out timing is unchanged.
module switch_conditioner #(
  parameter int N_CH            = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            change_strobe
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0]  sync_p0;
  logic [N_CH-1:0]  sync_p1;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  accept;

  // Next counter value: clears when stable or on acceptance, so it never
  // exceeds CNT_MAX and never wraps.
  function automatic logic [CNT_W-1:0] next_count(input logic pending,
                                                  input logic [CNT_W-1:0] cur);
    if (!pending || (cur == CNT_MAX)) return '0;
    return cur + CNT_W'(1);
  endfunction

  // Stage p0 -> p1: two-flop synchroniser, no logic between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
    end
  end

  // A channel accepts its new level when it has differed for the full window.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_CH; i++) begin
      accept[i] = (sync_p1[i] != clean_out[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // Stage p1 -> debounced level: per-channel persistence counters and clean_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      clean_out <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= next_count(sync_p1[i] != clean_out[i], cnt[i]);
      end
      clean_out <= clean_out ^ accept;
    end
  end

`ifdef SWITCH_COND_EDGE_EN
  // Edge pulses registered on the same edge that updates clean_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_pulse    <= '0;
      fall_pulse    <= '0;
      change_strobe <= 1'b0;
    end else begin
      rise_pulse    <= accept & ~clean_out;
      fall_pulse    <= accept &  clean_out;
      change_strobe <= |accept;
    end
  end
`else
  assign rise_pulse    = '0;
  assign fall_pulse    = '0;
  assign change_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner with N_CH=3, DEBOUNCE_CYCLES=4. The reference
// model tracks the synchronised level history and accepts a new level once the
// last DEBOUNCE_CYCLES synchronised samples all differ from the current output.
module tb_switch_conditioner;

  localparam int N_CH = 3;
  localparam int D    = 4;
`ifdef SWITCH_COND_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N_CH-1:0] raw_in = '0;
  logic [N_CH-1:0] clean_out, rise_pulse, fall_pulse;
  logic            change_strobe;
  logic [9:0]      obs;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [N_CH-1:0] m_s1, m_s2, m_clean, m_rise, m_fall;
  logic [N_CH-1:0] hist[$];

  switch_conditioner #(.N_CH(N_CH), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .clean_out(clean_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .change_strobe(change_strobe)
  );

  always #5 clk = ~clk;
  assign obs = {clean_out, rise_pulse, fall_pulse, change_strobe};

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
    hist.delete();
  endtask

  task automatic model_edge();
    logic [N_CH-1:0] fl;
    bit all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist.push_back(m_s2);
    if (hist.size() > D) void'(hist.pop_front());
    fl = '0;
    if (hist.size() == D) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        all_diff = 1'b1;
        foreach (hist[j]) if (hist[j][ch] == m_clean[ch]) all_diff = 1'b0;
        fl[ch] = all_diff;
      end
    end
    m_rise  = fl & ~m_clean;
    m_fall  = fl &  m_clean;
    m_clean = m_clean ^ fl;
    m_s2    = m_s1;
    m_s1    = raw_in;
  endtask

  function automatic logic [9:0] exp_vec();
    if (EDGE_EN) return {m_clean, m_rise, m_fall, |(m_rise | m_fall)};
    return {m_clean, 7'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    raw_in = 3'b111;
    rst_n  = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (obs !== 10'b0) begin
      n_err++;
      $display("FAIL reset_immediate: outputs=%b required=%b", obs, 10'b0);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (obs !== 10'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: outputs=%b required=%b", c, obs, 10'b0);
      end
    end
    raw_in = '0;
    rst_n  = 1'b1;
  endtask

  task automatic test_step();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL step_idle: outputs=%b required=%b", obs, exp_vec());
      end
    end
    raw_in[0] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL step_model edge%0d: outputs=%b required=%b", e, obs, exp_vec());
      end
      if (e == 5) begin
        n_cmp++;
        if (clean_out[0] !== 1'b0) begin
          n_err++;
          $display("FAIL step_early: clean_out[0]=%b required=0", clean_out[0]);
        end
      end
      if (e == 6) begin
        n_cmp++;
        if (clean_out[0] !== 1'b1 || rise_pulse[0] !== EDGE_EN || change_strobe !== EDGE_EN) begin
          n_err++;
          $display("FAIL step_edge6: clean=%b rise=%b strobe=%b required 1/%b/%b",
                   clean_out[0], rise_pulse[0], change_strobe, EDGE_EN, EDGE_EN);
        end
      end
      if (e == 7) begin
        n_cmp++;
        if (rise_pulse[0] !== 1'b0 || change_strobe !== 1'b0) begin
          n_err++;
          $display("FAIL step_pulse_width: rise=%b strobe=%b required 0/0",
                   rise_pulse[0], change_strobe);
        end
      end
    end
  endtask

  task automatic test_glitch();
    raw_in[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL glitch_model: outputs=%b required=%b", obs, exp_vec());
      end
    end
    raw_in[1] = 1'b0;
    for (int c = 0; c < 22; c++) begin
      tick();
      n_cmp++;
      if (clean_out[1] !== 1'b0 || rise_pulse[1] !== 1'b0 || fall_pulse[1] !== 1'b0 ||
          obs !== exp_vec()) begin
        n_err++;
        $display("FAIL glitch_reject cyc%0d: outputs=%b required=%b", c, obs, exp_vec());
      end
    end
  endtask

  task automatic test_bounce();
    int rises = 0;
    for (int seg = 0; seg < 6; seg++) begin
      raw_in[2] = (seg % 2 == 0);
      for (int c = 0; c < 2; c++) begin
        tick();
        if (rise_pulse[2] === 1'b1) rises++;
        n_cmp++;
        if (obs !== exp_vec()) begin
          n_err++;
          $display("FAIL bounce_model: outputs=%b required=%b", obs, exp_vec());
        end
      end
    end
    raw_in[2] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (rise_pulse[2] === 1'b1) rises++;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL bounce_hold edge%0d: outputs=%b required=%b", e, obs, exp_vec());
      end
      if (e == 5 || e == 6) begin
        n_cmp++;
        if (clean_out[2] !== (e == 6)) begin
          n_err++;
          $display("FAIL bounce_latency edge%0d: clean_out[2]=%b required=%0d",
                   e, clean_out[2], (e == 6));
        end
      end
    end
    n_cmp++;
    if (rises !== (EDGE_EN ? 1 : 0)) begin
      n_err++;
      $display("FAIL bounce_single_rise: rises=%0d required=%0d", rises, EDGE_EN ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    rst_n  = 1'b0;
    raw_in = '0;
    model_reset();
    tick();
    rst_n = 1'b1;
    raw_in[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL midrst_count: outputs=%b required=%b", obs, exp_vec());
      end
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (obs !== 10'b0) begin
      n_err++;
      $display("FAIL midrst_immediate: outputs=%b required=%b", obs, 10'b0);
    end
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL midrst_model edge%0d: outputs=%b required=%b", e, obs, exp_vec());
      end
      if (e == 5 || e == 6) begin
        n_cmp++;
        if (clean_out[0] !== (e == 6)) begin
          n_err++;
          $display("FAIL midrst_latency edge%0d: clean_out[0]=%b required=%0d",
                   e, clean_out[0], (e == 6));
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    raw_in = 3'b111;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL simul_setup: outputs=%b required=%b", obs, exp_vec());
      end
    end
    raw_in = 3'b000;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL simul_model edge%0d: outputs=%b required=%b", e, obs, exp_vec());
      end
      if (e == 5) begin
        n_cmp++;
        if (clean_out !== 3'b111) begin
          n_err++;
          $display("FAIL simul_early: clean_out=%b required=111", clean_out);
        end
      end
      if (e == 6) begin
        n_cmp++;
        if (clean_out !== 3'b000 || fall_pulse !== {3{EDGE_EN}} ||
            rise_pulse !== 3'b000 || change_strobe !== EDGE_EN) begin
          n_err++;
          $display("FAIL simul_fall: clean=%b fall=%b rise=%b strobe=%b required 000/%b/000/%b",
                   clean_out, fall_pulse, rise_pulse, change_strobe, {3{EDGE_EN}}, EDGE_EN);
        end
      end
      if (e == 7) begin
        n_cmp++;
        if (fall_pulse !== 3'b000 || change_strobe !== 1'b0) begin
          n_err++;
          $display("FAIL simul_pulse_width: fall=%b strobe=%b required 000/0",
                   fall_pulse, change_strobe);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (obs !== 10'b0) begin
          n_err++;
          $display("FAIL rand_reset: outputs=%b required=%b", obs, 10'b0);
        end
        tick();
        rst_n = 1'b1;
      end
      for (int ch = 0; ch < N_CH; ch++) begin
        if ($urandom_range(0, 6) == 0) raw_in[ch] = ~raw_in[ch];
      end
      tick();
      n_cmp++;
      if (obs !== exp_vec() || (rise_pulse & fall_pulse) !== 3'b000) begin
        n_err++;
        $display("FAIL rand_model cyc%0d: outputs=%b required=%b", c, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_step();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
